hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- AW, 5, register-address width.
- NFWD, 2, tracked stages beyond ID: entry 0 = EXE, entry 1 = MEM, ...
- RDYW, 2, width of a producer's ready-stage field.
- MD_LAT, 32, cycles of a multiply/divide operation.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- id_valid, in, 1, the ID instruction is real.
- id_rs / id_rt, in, AW each, source addresses.
- id_rs_rd / id_rt_rd, in, 1 each, source-read enables.
- id_wr_en, in, 1, the ID instruction writes the regfile.
- id_wr_addr, in, AW, destination address.
- id_rdy_stage, in, RDYW, entry index at which the result becomes forwardable: 0 = ALU at EXE, 1 = load at MEM.
- id_md_start, in, 1, the ID instruction is mult/multu/div/divu.
- id_hilo_rd, in, 1, the ID instruction is mfhi/mflo.
- flush, in, 1, exception/eret; kill all younger in-flight work.
- stall, out, 1, hold PC and IF/ID; insert a bubble into EXE.
- fwd_rs_sel / fwd_rt_sel, out, $clog2(NFWD+1) each: 0 = regfile, k+1 = forward from entry k.
- md_busy, out, 1, a multiply/divide is in progress.
- md_done, out, 1, one-cycle pulse when HI/LO are written.

Function
REQ-003 A shadow shift register of NFWD entries {v, addr, rdy} SHALL advance every cycle; entry k moves to k+1, and entry NFWD-1 retires.
REQ-004 Entry 0 SHALL load {id_valid & id_wr_en & ~stall & ~flush & (id_wr_addr!=0), id_wr_addr, id_rdy_stage}.
REQ-005 A source SHALL match entry k when its read enable is set, entry k's v=1, entry k's addr equals the source address, and the address is non-zero.
REQ-006 Among matching entries the youngest (lowest k) SHALL win; older matches are ignored.
REQ-007 When the winning match has k >= rdy, fwd_*_sel SHALL be k+1; with no match it SHALL be 0.
REQ-008 A winning match with k < rdy SHALL assert stall (load-use hazard).
REQ-009 stall SHALL also assert when id_valid and id_hilo_rd and md_busy are all set.
REQ-010 stall SHALL also assert when id_valid and id_md_start and md_busy are all set.
REQ-011 stall SHALL be combinational; it SHALL be forced to 0 when id_valid=0 or flush=1.
REQ-012 The multiply/divide FSM SHALL have states IDLE, BUSY and DONE.
- IDLE to BUSY on id_valid & id_md_start & ~stall & ~flush; the counter loads MD_LAT-1.
- BUSY decrements the counter each cycle and goes to DONE when it reaches 0.
- DONE lasts one cycle, asserts md_done, then returns to IDLE.
REQ-013 md_busy SHALL be 1 in BUSY and DONE.
REQ-014 A new start SHALL be accepted in the DONE cycle only after that cycle, i.e. from IDLE.
REQ-015 flush SHALL clear every shadow-entry v bit at the next edge.
REQ-016 flush SHALL NOT abort an in-progress multiply/divide, because that operation is older than the flushing instruction.
REQ-017 flush together with id_md_start SHALL NOT start the FSM.
REQ-018 Latency: a producer issued at cycle t SHALL be visible as entry 0 at cycle t+1.

Reset
REQ-019 While rst=1 (asynchronously), all v SHALL be 0, the FSM SHALL be IDLE, and the counter SHALL be 0.
REQ-020 While rst=1 the outputs SHALL be stall=0, fwd_*_sel=0, md_busy=0 and md_done=0.
REQ-021 Reset asserted mid-operation SHALL abandon any multiply/divide with no md_done pulse.

Structure
REQ-022 The shared cpu_pkg package SHALL hold:
- the fwd_sel encoding constants;
- the RDY_EXE=0 and RDY_MEM=1 constants;
- the md_state_t enum.
REQ-023 The multiply/divide FSM and counter SHALL be a sub-module, md_timer.
REQ-024 The per-source match/priority logic SHALL be a function or generate loop that is instantiated twice, once for rs and once for rt.

Verification
REQ-025 Back-to-back ALU: "add r3" followed by "sub r4,r3,r5" -> stall=0, fwd_rs_sel=1.
REQ-026 Load-use:
- "lw r3" followed by "add r4,r3,r3" -> stall=1 for exactly one cycle;
- the next cycle stall=0 and fwd_rs_sel=fwd_rt_sel=2.
REQ-027 r0 and youngest-wins:
- writes to r0 never match;
- r7 written at entry 0 and at entry 1 -> fwd_rs_sel=1.
REQ-028 div, then mflo at the next cycle:
- stall=1 for MD_LAT+1 cycles;
- md_done pulses exactly once;
- mflo proceeds in the cycle after DONE.
REQ-029 Flush:
- lw pending with a consumer in ID, then flush=1 -> stall=0 that cycle, and all v=0 afterwards;
- a running divide still completes with md_done.
REQ-030 Async reset asserted mid-BUSY -> md_busy=0 immediately, and md_done never pulses.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline constants and types for the hazard scoreboard and its
// multiply/divide timer.
package cpu_pkg;

    // Forwarding select encoding: 0 takes the regfile, k+1 takes shadow entry k.
    localparam int FWD_SEL_RF  = 0;
    localparam int FWD_SEL_EXE = 1;
    localparam int FWD_SEL_MEM = 2;

    // Entry index at which a producer's result becomes forwardable.
    localparam int RDY_EXE = 0;
    localparam int RDY_MEM = 1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/hazard_scoreboard_md_timer.sv
// Multiply/divide occupancy timer: IDLE -> BUSY (MD_LAT cycles) -> DONE (one
// cycle, HI/LO written) -> IDLE.  Only a flush-free, unstalled start is seen here.
module md_timer
    import cpu_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_start,
    output logic      o_busy,
    output logic      o_done,
    output md_state_t o_state
);

    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    md_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_state <= MD_BUSY;
                        r_cnt   <= CW'(MD_LAT - 1);
                        r_busy  <= 1'b1;
                    end
                end
                // The count runs MD_LAT-1 down to 0 inclusive: MD_LAT BUSY cycles.
                MD_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= MD_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                MD_DONE: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_state = r_state;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight register writers in a shadow
// shift register, selects forwarding paths, and stalls on load-use and HI/LO use.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int  AW     = 5,
    parameter int  NFWD   = 2,
    parameter int  RDYW   = 2,
    parameter int  MD_LAT = 32,
    localparam int SELW   = $clog2(NFWD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_rd,
    input  logic            id_rt_rd,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_wr_addr,
    input  logic [RDYW-1:0] id_rdy_stage,
    input  logic            id_md_start,
    input  logic            id_hilo_rd,
    input  logic            flush,
    output logic            stall,
    output logic [SELW-1:0] fwd_rs_sel,
    output logic [SELW-1:0] fwd_rt_sel,
    output logic            md_busy,
    output logic            md_done,
    output md_state_t       dbg_md_state
);

    logic            r_v    [NFWD];
    logic [AW-1:0]   r_addr [NFWD];
    logic [RDYW-1:0] r_rdy  [NFWD];

    logic            w_alloc;
    logic            w_md_start;
    logic [SELW:0]   w_rs_res;
    logic [SELW:0]   w_rt_res;

    // Returns {hazard, sel}. Scanning oldest to youngest lets the youngest
    // matching entry overwrite any older one.
    function automatic logic [SELW:0] resolve(input logic rd_en, input logic [AW-1:0] src);
        logic [SELW-1:0] sel;
        logic            hz;
        sel = SELW'(FWD_SEL_RF);
        hz  = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (rd_en && r_v[k] && (r_addr[k] == src) && (src != '0)) begin
                if (k >= int'(r_rdy[k])) begin
                    sel = SELW'(k + 1);
                    hz  = 1'b0;
                end else begin
                    sel = SELW'(FWD_SEL_RF);
                    hz  = 1'b1;
                end
            end
        end
        return {hz, sel};
    endfunction

    always_comb begin
        w_rs_res = resolve(id_rs_rd, id_rs);
        w_rt_res = resolve(id_rt_rd, id_rt);
    end

    assign fwd_rs_sel = w_rs_res[SELW-1:0];
    assign fwd_rt_sel = w_rt_res[SELW-1:0];

    // md_busy covers DONE too, so a follow-on mfhi/mflo or start waits until IDLE.
    assign stall = id_valid & ~flush &
                   (w_rs_res[SELW] | w_rt_res[SELW] |
                    (md_busy & (id_hilo_rd | id_md_start)));

    assign w_alloc    = id_valid & id_wr_en & ~stall & ~flush & (id_wr_addr != '0);
    assign w_md_start = id_valid & id_md_start & ~stall & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NFWD; k++) begin
                r_v[k]    <= 1'b0;
                r_addr[k] <= '0;
                r_rdy[k]  <= '0;
            end
        end else begin
            r_v[0]    <= w_alloc;
            r_addr[0] <= id_wr_addr;
            r_rdy[0]  <= id_rdy_stage;
            // Everything in flight is younger than the flushing instruction.
            for (int k = 1; k < NFWD; k++) begin
                r_v[k]    <= r_v[k-1] & ~flush;
                r_addr[k] <= r_addr[k-1];
                r_rdy[k]  <= r_rdy[k-1];
            end
        end
    end

    md_timer #(
        .MD_LAT (MD_LAT)
    ) u_md_timer (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_md_start),
        .o_busy  (md_busy),
        .o_done  (md_done),
        .o_state (dbg_md_state)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus
// random traffic, compared each cycle against an age-ordered writer history model.
module tb_hazard_scoreboard;
    import cpu_pkg::*;

    localparam int AW     = 5;
    localparam int NFWD   = 2;
    localparam int RDYW   = 2;
    localparam int MD_LAT = 32;
    localparam int SELW   = $clog2(NFWD + 1);
    localparam int EW     = 9;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [AW-1:0]   id_rs;
    logic [AW-1:0]   id_rt;
    logic            id_rs_rd;
    logic            id_rt_rd;
    logic            id_wr_en;
    logic [AW-1:0]   id_wr_addr;
    logic [RDYW-1:0] id_rdy_stage;
    logic            id_md_start;
    logic            id_hilo_rd;
    logic            flush;
    logic            stall;
    logic [SELW-1:0] fwd_rs_sel;
    logic [SELW-1:0] fwd_rt_sel;
    logic            md_busy;
    logic            md_done;
    md_state_t       dbg_md_state;

    hazard_scoreboard #(
        .AW(AW), .NFWD(NFWD), .RDYW(RDYW), .MD_LAT(MD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_wr_en(id_wr_en),
        .id_wr_addr(id_wr_addr), .id_rdy_stage(id_rdy_stage),
        .id_md_start(id_md_start), .id_hilo_rd(id_hilo_rd), .flush(flush),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .md_busy(md_busy), .md_done(md_done), .dbg_md_state(dbg_md_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Writer history, index = age in cycles since issue (0 = youngest).
    typedef struct packed {
        logic            v;
        logic [AW-1:0]   a;
        logic [RDYW-1:0] r;
    } ent_t;

    ent_t             hist[$];
    bit               md_on;
    int               md_s;
    int               cyc;
    logic [EW-1:0]    exp_q[$];
    int               total;
    int               bad;
    int               done_cnt;
    logic             last_stall;
    logic [SELW-1:0]  last_rs;
    logic [SELW-1:0]  last_rt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < NFWD; i++) hist.push_back('0);
        md_on = 1'b0;
        md_s  = 0;
    endtask

    function automatic void resolve_m(input logic rd, input logic [AW-1:0] src,
                                      output int sel, output bit hz);
        sel = 0;
        hz  = 1'b0;
        if (rd && src != '0) begin
            for (int age = 0; age < hist.size(); age++) begin
                if (hist[age].v && hist[age].a == src) begin
                    if (age >= int'(hist[age].r)) sel = age + 1;
                    else hz = 1'b1;
                    break;
                end
            end
        end
    endfunction

    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic rsr,
                         input logic [AW-1:0] rt, input logic rtr, input logic we,
                         input logic [AW-1:0] wa, input logic [RDYW-1:0] rdy,
                         input logic md, input logic hilo, input logic fl);
        id_valid = v;      id_rs = rs;        id_rs_rd = rsr;
        id_rt = rt;        id_rt_rd = rtr;    id_wr_en = we;
        id_wr_addr = wa;   id_rdy_stage = rdy;
        id_md_start = md;  id_hilo_rd = hilo; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    task automatic cycle();
        int            rs_sel, rt_sel;
        bit            rs_hz, rt_hz, e_busy, e_done, e_stall, acc;
        logic [EW-1:0] e;
        #1;
        if (rst) begin
            rs_sel = 0; rt_sel = 0; rs_hz = 0; rt_hz = 0;
            e_busy = 0; e_done = 0; e_stall = 0;
        end else begin
            resolve_m(id_rs_rd, id_rs, rs_sel, rs_hz);
            resolve_m(id_rt_rd, id_rt, rt_sel, rt_hz);
            e_busy  = md_on && (cyc > md_s) && (cyc <= md_s + MD_LAT + 1);
            e_done  = md_on && (cyc == md_s + MD_LAT + 1);
            e_stall = id_valid && !flush &&
                      (rs_hz || rt_hz || (e_busy && (id_hilo_rd || id_md_start)));
        end
        exp_q.push_back({e_stall, SELW'(rs_sel), !rs_hz, SELW'(rt_sel), !rt_hz, e_busy, e_done});
        e = exp_q.pop_front();
        check("stall", 32'(stall), 32'(e[8]));
        if (e[5]) check("fwd_rs_sel", 32'(fwd_rs_sel), 32'(e[7:6]));
        if (e[2]) check("fwd_rt_sel", 32'(fwd_rt_sel), 32'(e[4:3]));
        check("md_busy", 32'(md_busy), 32'(e[1]));
        check("md_done", 32'(md_done), 32'(e[0]));
        last_stall = stall;
        last_rs    = fwd_rs_sel;
        last_rt    = fwd_rt_sel;
        if (md_done === 1'b1) done_cnt++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc = id_valid && !e_stall && !flush;
            hist.push_front('{v: acc && id_wr_en && (id_wr_addr != '0), a: id_wr_addr, r: id_rdy_stage});
            if (hist.size() > NFWD) void'(hist.pop_back());
            if (flush) foreach (hist[i]) hist[i].v = 1'b0;
            if (acc && id_md_start) begin
                md_on = 1'b1;
                md_s  = cyc;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Hold the current ID instruction until it issues; returns stalled cycles.
    task automatic run_until_go(input int limit, output int stalls);
        stalls = 0;
        for (int i = 0; i < limit; i++) begin
            cycle();
            if (last_stall !== 1'b1) return;
            stalls++;
        end
        check("issue_timeout", 32'(1), 32'(0));
    endtask

    int n;

    initial begin
        total = 0; bad = 0; cyc = 0; done_cnt = 0;
        model_reset();
        rst = 1'b1;
        // Busy inputs under reset: outputs must still be quiet.
        drive(1, 3, 1, 3, 1, 1, 3, 1, 1, 1, 0);
        @(negedge clk);
        repeat (3) cycle();
        idle();
        rst = 1'b0;
        cycle();

        // Back-to-back ALU: add r3 ; sub r4,r3,r5
        drive(1, 1, 1, 2, 1, 1, 3, RDY_EXE, 0, 0, 0); cycle();
        drive(1, 3, 1, 5, 1, 1, 4, RDY_EXE, 0, 0, 0); cycle();
        check("alu_stall", 32'(last_stall), 32'(0));
        check("alu_fwd_rs", 32'(last_rs), 32'(FWD_SEL_EXE));

        // Load-use: lw r3 ; add r4,r3,r3
        drive(1, 1, 1, 0, 0, 1, 3, RDY_MEM, 0, 0, 0); cycle();
        drive(1, 3, 1, 3, 1, 1, 4, RDY_EXE, 0, 0, 0);
        run_until_go(10, n);
        check("lu_stall_cycles", 32'(n), 32'(1));
        check("lu_fwd_rs", 32'(last_rs), 32'(FWD_SEL_MEM));
        check("lu_fwd_rt", 32'(last_rt), 32'(FWD_SEL_MEM));

        // r0 never matches; youngest of two r7 writers wins.
        drive(1, 1, 1, 0, 0, 1, 0, RDY_EXE, 0, 0, 0); cycle();
        drive(1, 0, 1, 0, 1, 1, 6, RDY_EXE, 0, 0, 0); cycle();
        check("r0_fwd_rs", 32'(last_rs), 32'(FWD_SEL_RF));
        drive(1, 1, 1, 0, 0, 1, 7, RDY_EXE, 0, 0, 0); cycle();
        drive(1, 2, 1, 0, 0, 1, 7, RDY_EXE, 0, 0, 0); cycle();
        drive(1, 7, 1, 7, 1, 1, 8, RDY_EXE, 0, 0, 0); cycle();
        check("young_fwd_rs", 32'(last_rs), 32'(FWD_SEL_EXE));
        check("young_stall", 32'(last_stall), 32'(0));

        // div ; mflo
        drive(1, 1, 1, 2, 1, 0, 0, RDY_EXE, 1, 0, 0); cycle();
        done_cnt = 0;
        drive(1, 0, 0, 0, 0, 1, 9, RDY_EXE, 0, 1, 0);
        run_until_go(MD_LAT + 20, n);
        check("div_stall_cycles", 32'(n), 32'(MD_LAT + 1));
        check("div_done_pulses", 32'(done_cnt), 32'(1));

        // Flush with a load-use pending while a divide runs.
        done_cnt = 0;
        drive(1, 1, 1, 2, 1, 0, 0, RDY_EXE, 1, 0, 0); cycle();
        drive(1, 1, 1, 0, 0, 1, 3, RDY_MEM, 0, 0, 0); cycle();
        drive(1, 3, 1, 0, 0, 1, 4, RDY_EXE, 0, 0, 1); cycle();
        check("flush_stall", 32'(last_stall), 32'(0));
        drive(1, 3, 1, 3, 1, 1, 4, RDY_EXE, 0, 0, 0); cycle();
        check("flush_clr_stall", 32'(last_stall), 32'(0));
        check("flush_clr_fwd", 32'(last_rs), 32'(FWD_SEL_RF));
        idle();
        for (int i = 0; i < MD_LAT + 10 && done_cnt == 0; i++) cycle();
        check("flush_div_done", 32'(done_cnt), 32'(1));
        idle(); cycle();

        // Asynchronous reset in the middle of a divide.
        drive(1, 1, 1, 2, 1, 0, 0, RDY_EXE, 1, 0, 0); cycle();
        idle();
        repeat (10) cycle();
        check("pre_rst_busy", 32'(md_busy), 32'(1));
        #3 rst = 1'b1;
        #1;
        check("arst_busy", 32'(md_busy), 32'(0));
        check("arst_done", 32'(md_done), 32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (MD_LAT + 5) cycle();
        check("arst_no_done", 32'(done_cnt), 32'(0));

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0,
                  AW'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 4)),
                  RDYW'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 15) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
